// File: rtl/sr_ff_monitor.sv
// Reference-model checker for an external SR flip-flop: predicts q one cycle after each s/r sample,
// flags q/qc disagreements and illegal s=r=1 drives, and keeps saturating event counters.
module sr_ff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qc,
  output logic             exp_q,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             illegal,
  output logic             fail,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  typedef enum logic [1:0] {
    ST_UNINIT  = 2'b00,
    ST_KNOWN   = 2'b01,
    ST_UNKNOWN = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic             mismatch_q, mismatch_d;
  logic             illegal_q, illegal_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic do_check;
  logic bad_out;
  logic mm_hit;
  logic ill_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
  endfunction

  // The check compares against the model as it stood before this edge's s/r sample is applied.
  always_comb begin
    do_check = en && (state_q == ST_KNOWN);
    bad_out  = (q != exp_q_q) || (qc != ~q);
    mm_hit   = do_check && bad_out;
    ill_hit  = en && s && r;

    state_d    = state_q;
    exp_q_d    = exp_q_q;
    mismatch_d = mm_hit;
    illegal_d  = ill_hit;
    fail_d     = fail_q | mm_hit;
    chk_cnt_d  = sat_inc(chk_cnt_q, do_check);
    err_cnt_d  = sat_inc(err_cnt_q, mm_hit);
    ill_cnt_d  = sat_inc(ill_cnt_q, ill_hit);

    if (en) begin
      case ({s, r})
        2'b10: begin
          exp_q_d = 1'b1;
          state_d = ST_KNOWN;
        end
        2'b01: begin
          exp_q_d = 1'b0;
          state_d = ST_KNOWN;
        end
        2'b11: state_d = ST_UNKNOWN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_UNINIT;
      exp_q_q    <= 1'b0;
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
      fail_q     <= 1'b0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ill_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q_q    <= exp_q_d;
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      fail_q     <= fail_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign exp_q    = exp_q_q;
  assign state    = state_q;
  assign mismatch = mismatch_q;
  assign illegal  = illegal_q;
  assign fail     = fail_q;
  assign chk_cnt  = chk_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign ill_cnt  = ill_cnt_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Scoreboard bench for sr_ff_monitor: one CNT_W=8 and one CNT_W=2 instance share directed stimulus.
module tb_sr_ff_monitor;

  logic clk;
  logic rst, en, s, r, q, qc;

  logic       eq8, mm8, il8, fl8;
  logic [1:0] st8;
  logic [7:0] chk8, err8, ill8;
  logic       eq2, mm2, il2, fl2;
  logic [1:0] st2;
  logic [1:0] chk2, err2, ill2;

  sr_ff_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qc(qc),
    .exp_q(eq8), .state(st8), .mismatch(mm8), .illegal(il8), .fail(fl8),
    .chk_cnt(chk8), .err_cnt(err8), .ill_cnt(ill8)
  );

  sr_ff_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qc(qc),
    .exp_q(eq2), .state(st2), .mismatch(mm2), .illegal(il2), .fail(fl2),
    .chk_cnt(chk2), .err_cnt(err2), .ill_cnt(ill2)
  );

  typedef struct {
    logic       eq;
    logic [1:0] st;
    logic       mm;
    logic       il;
    logic       fl;
    int         chk;
    int         err;
    int         ill;
    int         idx;
  } exp_t;

  typedef struct {
    logic rst, en, s, r, q, qc;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst_v, en_v, s_v, r_v, q_v, qc_v,
                     input logic eq_v, input logic [1:0] st_v, input logic mm_v, il_v, fl_v,
                     input int chk_v, err_v, ill_v);
    vec_t v;
    v.rst = rst_v; v.en = en_v; v.s = s_v; v.r = r_v; v.q = q_v; v.qc = qc_v;
    v.e.eq = eq_v; v.e.st = st_v; v.e.mm = mm_v; v.e.il = il_v; v.e.fl = fl_v;
    v.e.chk = chk_v; v.e.err = err_v; v.e.ill = ill_v; v.e.idx = vecs.size();
    vecs.push_back(v);
  endtask

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic a_eq, input logic [1:0] a_st, input logic a_mm, a_il, a_fl,
                     input int a_chk, a_err, a_ill,
                     input logic e_eq, input logic [1:0] e_st, input logic e_mm, e_il, e_fl,
                     input int e_chk, e_err, e_ill);
    checks++;
    if (a_eq !== e_eq || a_st !== e_st || a_mm !== e_mm || a_il !== e_il || a_fl !== e_fl ||
        a_chk != e_chk || a_err != e_err || a_ill != e_ill) begin
      errors++;
      $display("FAIL %s vec%0d: got exp_q=%0b state=%0b mm=%0b il=%0b fail=%0b chk=%0d err=%0d ill=%0d; want exp_q=%0b state=%0b mm=%0b il=%0b fail=%0b chk=%0d err=%0d ill=%0d",
               name, idx, a_eq, a_st, a_mm, a_il, a_fl, a_chk, a_err, a_ill,
               e_eq, e_st, e_mm, e_il, e_fl, e_chk, e_err, e_ill);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge following each sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("dut8", e.idx, eq8, st8, mm8, il8, fl8, int'(chk8), int'(err8), int'(ill8),
            e.eq, e.st, e.mm, e.il, e.fl, e.chk, e.err, e.ill);
        cmp("dut2", e.idx, eq2, st2, mm2, il2, fl2, int'(chk2), int'(err2), int'(ill2),
            e.eq, e.st, e.mm, e.il, e.fl, sat2(e.chk), sat2(e.err), sat2(e.ill));
      end
    end
  end

  initial begin
    // rst en s r q qc | exp_q state mm il fail chk err ill
    add(1,1,1,1,0,1, 0,2'b00,0,0,0, 0,0,0);
    add(1,0,0,0,0,1, 0,2'b00,0,0,0, 0,0,0);
    add(0,1,0,0,0,1, 0,2'b00,0,0,0, 0,0,0);
    add(0,1,0,0,0,1, 0,2'b00,0,0,0, 0,0,0);
    add(0,1,0,0,0,1, 0,2'b00,0,0,0, 0,0,0);
    add(0,1,1,0,0,1, 1,2'b01,0,0,0, 0,0,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,0, 1,0,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,0, 2,0,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,0, 3,0,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,0, 4,0,0);
    add(0,1,0,0,0,1, 1,2'b01,1,0,1, 5,1,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,1, 6,1,0);
    add(0,1,0,0,1,1, 1,2'b01,1,0,1, 7,2,0);
    add(0,1,1,1,0,1, 1,2'b10,1,1,1, 8,3,1);
    add(0,0,1,0,0,0, 1,2'b10,0,0,1, 8,3,1);
    add(0,1,0,0,0,1, 1,2'b10,0,0,1, 8,3,1);
    add(0,1,1,0,0,1, 1,2'b01,0,0,1, 8,3,1);
    add(0,1,0,1,1,0, 0,2'b01,0,0,1, 9,3,1);
    add(0,1,1,1,0,1, 0,2'b10,0,1,1, 10,3,2);
    add(0,1,0,0,0,1, 0,2'b10,0,0,1, 10,3,2);
    add(0,1,0,1,0,1, 0,2'b01,0,0,1, 10,3,2);
    add(0,1,0,0,0,1, 0,2'b01,0,0,1, 11,3,2);
    add(0,1,0,0,1,0, 0,2'b01,1,0,1, 12,4,2);
    add(0,1,0,0,1,0, 0,2'b01,1,0,1, 13,5,2);
    add(1,1,1,0,1,0, 0,2'b00,0,0,0, 0,0,0);
    add(0,1,1,0,0,1, 1,2'b01,0,0,0, 0,0,0);
    add(0,1,0,0,1,0, 1,2'b01,0,0,0, 1,0,0);
    add(0,1,0,0,0,1, 1,2'b01,1,0,1, 2,1,0);
    add(0,0,0,0,0,1, 1,2'b01,0,0,1, 2,1,0);

    rst = 1'b1; en = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0; qc = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      #1;
      rst = vecs[i].rst; en = vecs[i].en; s = vecs[i].s; r = vecs[i].r;
      q = vecs[i].q; qc = vecs[i].qc;
      @(posedge clk);
      sb.push_back(vecs[i].e);
    end
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(drv_done && sb.size() == 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0 || !drv_done) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, driver done=%0b; want 0 left and done", sb.size(), drv_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
